div_unit: RTL and testbench

- Multi-cycle signed integer divider for the MIPS multi-cycle datapath, implementing DIV.
- Sits between registers A/B and the DivCtrl muxes feeding HI/LO.
- Consumes A (dividend) and B (divisor); produces the quotient (to LO) and the remainder (to HI).
- Raises a divide-by-zero flag that the control unit routes to exception handling (EPC / vector).

---
 rtl/div_unit.sv | 161 ++++++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV: quotient to LO, remainder to HI, div-by-zero pulse.
// Optional DIVU support is enabled by defining DIV_UNIT_DIVU_EN (adds the is_unsigned input).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef DIV_UNIT_DIVU_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    counter_q, counter_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             op_unsigned;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

`ifdef DIV_UNIT_DIVU_EN
    assign op_unsigned = is_unsigned;
`else
    assign op_unsigned = 1'b0;
`endif

    // Magnitudes are treated as unsigned, so |0x80..0| stays 0x80..0 without overflow.
    assign abs_a = (!op_unsigned && a[WIDTH-1]) ? -a : a;
    assign abs_b = (!op_unsigned && b[WIDTH-1]) ? -b : b;

    // Two guard bits: the shifted remainder can reach WIDTH+1 bits, the top bit is the borrow.
    assign shifted = {1'b0, rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs_q};

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        div_zero_d = 1'b1;
                    end else begin
                        quo_d      = abs_a;
                        dvs_d      = abs_b;
                        rem_d      = '0;
                        sign_quo_d = !op_unsigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_rem_d = !op_unsigned && a[WIDTH-1];
                        counter_d  = '0;
                        busy_d     = 1'b1;
                        state_d    = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (!trial[WIDTH+1]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                counter_d = counter_q + CW'(1);
                if (counter_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                lo_d    = sign_quo_q ? -quo_q : quo_q;
                hi_d    = sign_rem_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            counter_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed scenarios plus random signed divisions checked
// against an arithmetic reference model through an expected queue.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
    logic [1:0]  state_dbg;
`ifdef DIV_UNIT_DIVU_EN
    logic        is_unsigned = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int k_cyc  = 0;

    logic [63:0] exp_q[$];

    div_unit #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
`ifdef DIV_UNIT_DIVU_EN
        .is_unsigned(is_unsigned),
`endif
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .state_dbg (state_dbg)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // reference: signed division truncating toward zero, remainder follows dividend
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [31:0] q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = 32'(sx / sy);
        r  = 32'(sx % sy);
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive start for one cycle; returns just after the sampling edge
    task automatic issue_start(input logic [31:0] op_a, input logic [31:0] op_b);
        @(negedge clock);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clock);
        #1;
        k_cyc = cyc;
        start = 1'b0;
        if (op_b != 32'd0) exp_q.push_back(ref_div(op_a, op_b));
    endtask

    // wait for done (bounded), checking latency, busy window and results
    task automatic wait_done(input string tag);
        int busy_bad;
        logic [63:0] exp;
        busy_bad = 0;
        if (!busy) busy_bad++;
        while (!done && (cyc - k_cyc) < 40) begin
            @(posedge clock);
            #1;
            if (!done && !busy) busy_bad++;
            if (div_zero) busy_bad++;
        end
        check({tag, "_latency"}, 32'(cyc - k_cyc), 32'd33);
        check({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        else exp = '0;
        check({tag, "_lo"}, lo, exp[31:0]);
        check({tag, "_hi"}, hi, exp[63:32]);
        @(posedge clock);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold_lo"}, lo, exp[31:0]);
    endtask

    initial begin
        logic [31:0] ra, rb;

        // reset
        repeat (3) @(posedge clock);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // basic signed cases
        issue_start(32'd7, 32'd2);
        wait_done("p7_2");
        issue_start(32'hFFFF_FFF9, 32'd2);
        wait_done("m7_2");
        issue_start(32'd7, 32'hFFFF_FFFE);
        wait_done("p7_m2");
        issue_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("min_m1");
        check("min_m1_lo_const", lo, 32'h8000_0000);
        issue_start(32'h8000_0000, 32'h8000_0000);
        wait_done("min_min");

        // divide by zero keeps hi/lo and never completes
        issue_start(32'd100, 32'd7);
        wait_done("pre_100_7");
        issue_start(32'd5, 32'd0);
        check("dz_pulse", {31'd0, div_zero}, 32'd1);
        check("dz_busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        check("dz_pulse_end", {31'd0, div_zero}, 32'd0);
        begin
            int saw_done;
            saw_done = 0;
            repeat (36) begin
                @(posedge clock);
                #1;
                if (done || busy) saw_done++;
            end
            check("dz_no_done", 32'(saw_done), 32'd0);
        end
        check("dz_hi_kept", hi, 32'd2);
        check("dz_lo_kept", lo, 32'd14);

        // start while busy is ignored, operands latched
        issue_start(32'd100, 32'd7);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        wait_done("mid_start");
        check("mid_start_idle", {31'd0, busy}, 32'd0);

        // reset mid-operation aborts
        issue_start(32'd100, 32'd7);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        void'(exp_q.pop_front());
        issue_start(32'd9, 32'd3);
        wait_done("after_abort");

        // random operands, mixed magnitudes and signs
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 15));
                default: rb = -32'($urandom_range(1, 300));
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50));
            if (rb == 32'd0) rb = 32'd1;
            issue_start(ra, rb);
            wait_done($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
